// File: rtl/vmask_pkg.sv
// Shared definitions for the vALU mask-reduction stage (vcpop.m / vfirst.m).
package vmask_pkg;

    localparam int unsigned VMR_MAX_W = 256;

    localparam logic VMR_CPOP  = 1'b0;
    localparam logic VMR_FIRST = 1'b1;

    typedef enum logic {
        VMR_IDLE  = 1'b0,
        VMR_ACCUM = 1'b1
    } vmr_state_e;

    // Low n bits set; caller truncates to its word width and clamps n first.
    function automatic logic [VMR_MAX_W-1:0] lanemask(input int unsigned n);
        logic [VMR_MAX_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < VMR_MAX_W; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/v_mask_reduce_word_scan.sv
// Combinational popcount and lowest-set-bit priority encoder over one mask word.
module v_mask_word_scan #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0]           w_i,
    output logic [$clog2(W):0]     pop_c,
    output logic [$clog2(W)-1:0]   ffs_c,
    output logic                   hit_c
);
    localparam int unsigned FFS_W = $clog2(W);
    localparam int unsigned POP_W = FFS_W + 1;

    always_comb begin
        pop_c = '0;
        ffs_c = '0;
        for (int i = 0; i < int'(W); i++) begin
            pop_c = pop_c + POP_W'(w_i[i]);
        end
        // Descending scan so the lowest set bit wins.
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (w_i[i]) begin
                ffs_c = FFS_W'(i);
            end
        end
        hit_c = |w_i;
    end

endmodule

// File: rtl/v_mask_reduce.sv
// Mask-reduction pipeline: S0 masks the word, S1 scans it, S2 accumulates a
// vector's words and emits one scalar (cpop or first) to writeback.
module v_mask_reduce
    import vmask_pkg::*;
#(
    parameter int unsigned REQ_DATA_WIDTH  = 64,
    parameter int unsigned RESP_DATA_WIDTH = 64,
    parameter int unsigned REQ_ADDR_WIDTH  = 32,
    parameter int unsigned LANE_WIDTH      = 7,
    parameter int unsigned IDX_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [REQ_DATA_WIDTH-1:0]  in_m0,
    input  logic [REQ_DATA_WIDTH-1:0]  in_v0,
    input  logic                       in_vm,
    input  logic [LANE_WIDTH-1:0]      in_lanes,
    input  logic                       in_last,
    input  logic                       in_opSel,
    input  logic [REQ_ADDR_WIDTH-1:0]  in_addr,
    output logic                       out_valid,
    output logic [RESP_DATA_WIDTH-1:0] out_scalar,
    output logic [REQ_ADDR_WIDTH-1:0]  out_addr
);
    localparam int unsigned W     = REQ_DATA_WIDTH;
    localparam int unsigned FFS_W = $clog2(W);
    localparam int unsigned POP_W = FFS_W + 1;

    // S0 registers
    logic                      s0_valid_q, s0_valid_d;
    logic [W-1:0]              s0_w_q, s0_w_d;
    logic                      s0_last_q, s0_last_d;
    logic                      s0_op_q, s0_op_d;
    logic [REQ_ADDR_WIDTH-1:0] s0_addr_q, s0_addr_d;
    // S1 registers
    logic                      s1_valid_q, s1_valid_d;
    logic [POP_W-1:0]          s1_pop_q, s1_pop_d;
    logic [FFS_W-1:0]          s1_ffs_q, s1_ffs_d;
    logic                      s1_hit_q, s1_hit_d;
    logic                      s1_last_q, s1_last_d;
    logic                      s1_op_q, s1_op_d;
    logic [REQ_ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
    // S2 accumulator and FSM
    vmr_state_e                 state_q, state_d;
    logic [RESP_DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [RESP_DATA_WIDTH-1:0] first_q, first_d;
    logic                       found_q, found_d;
    logic [IDX_WIDTH-1:0]       widx_q, widx_d;
    logic                       op_q, op_d;
    logic [REQ_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                       emit_q, emit_d;
    // Output registers
    logic                       out_valid_q, out_valid_d;
    logic [RESP_DATA_WIDTH-1:0] out_scalar_q, out_scalar_d;
    logic [REQ_ADDR_WIDTH-1:0]  out_addr_q, out_addr_d;

    logic [POP_W-1:0] scan_pop_c;
    logic [FFS_W-1:0] scan_ffs_c;
    logic             scan_hit_c;
    int unsigned      lanes_n;

    // S0: clamp lane count, apply v0 and lane masks.
    always_comb begin
        lanes_n    = (32'(in_lanes) > W) ? W : 32'(in_lanes);
        s0_valid_d = in_valid;
        s0_w_d     = '0;
        s0_last_d  = in_last;
        s0_op_d    = in_opSel;
        s0_addr_d  = in_addr;
        if (in_valid) begin
            s0_w_d = in_m0 & (in_vm ? {W{1'b1}} : in_v0) & W'(lanemask(lanes_n));
        end
    end

    v_mask_word_scan #(.W(W)) u_scan (
        .w_i   (s0_w_q),
        .pop_c (scan_pop_c),
        .ffs_c (scan_ffs_c),
        .hit_c (scan_hit_c)
    );

    always_comb begin
        s1_valid_d = s0_valid_q;
        s1_pop_d   = scan_pop_c;
        s1_ffs_d   = scan_ffs_c;
        s1_hit_d   = scan_hit_c;
        s1_last_d  = s0_last_q;
        s1_op_d    = s0_op_q;
        s1_addr_d  = s0_addr_q;
    end

    // S2: accumulate FSM; invalid cycles hold all state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        found_d = found_q;
        widx_d  = widx_q;
        op_d    = op_q;
        addr_d  = addr_q;
        emit_d  = 1'b0;
        if (s1_valid_q) begin
            case (state_q)
                VMR_IDLE: begin
                    op_d    = s1_op_q;
                    addr_d  = s1_addr_q;
                    cnt_d   = RESP_DATA_WIDTH'(s1_pop_q);
                    widx_d  = IDX_WIDTH'(1);
                    found_d = s1_hit_q;
                    first_d = RESP_DATA_WIDTH'(s1_ffs_q);
                    if (s1_last_q) begin
                        emit_d = 1'b1;
                    end else begin
                        state_d = VMR_ACCUM;
                    end
                end
                VMR_ACCUM: begin
                    cnt_d = cnt_q + RESP_DATA_WIDTH'(s1_pop_q);
                    if (!found_q && s1_hit_q) begin
                        first_d = (RESP_DATA_WIDTH'(widx_q) << FFS_W) + RESP_DATA_WIDTH'(s1_ffs_q);
                        found_d = 1'b1;
                    end
                    if (widx_q != {IDX_WIDTH{1'b1}}) begin
                        widx_d = widx_q + IDX_WIDTH'(1);
                    end
                    if (s1_last_q) begin
                        emit_d  = 1'b1;
                        state_d = VMR_IDLE;
                    end
                end
                default: state_d = VMR_IDLE;
            endcase
        end
    end

    // Output stage reads the pre-update accumulator, so a following vector may overwrite it.
    always_comb begin
        out_valid_d  = emit_q;
        out_scalar_d = out_scalar_q;
        out_addr_d   = out_addr_q;
        if (emit_q) begin
            out_addr_d = addr_q;
            if (op_q == VMR_FIRST) begin
                out_scalar_d = found_q ? first_q : {RESP_DATA_WIDTH{1'b1}};
            end else begin
                out_scalar_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q   <= 1'b0;
            s0_w_q       <= '0;
            s0_last_q    <= 1'b0;
            s0_op_q      <= 1'b0;
            s0_addr_q    <= '0;
            s1_valid_q   <= 1'b0;
            s1_pop_q     <= '0;
            s1_ffs_q     <= '0;
            s1_hit_q     <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_op_q      <= 1'b0;
            s1_addr_q    <= '0;
            state_q      <= VMR_IDLE;
            cnt_q        <= '0;
            first_q      <= '0;
            found_q      <= 1'b0;
            widx_q       <= '0;
            op_q         <= 1'b0;
            addr_q       <= '0;
            emit_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_scalar_q <= '0;
            out_addr_q   <= '0;
        end else begin
            s0_valid_q   <= s0_valid_d;
            s0_w_q       <= s0_w_d;
            s0_last_q    <= s0_last_d;
            s0_op_q      <= s0_op_d;
            s0_addr_q    <= s0_addr_d;
            s1_valid_q   <= s1_valid_d;
            s1_pop_q     <= s1_pop_d;
            s1_ffs_q     <= s1_ffs_d;
            s1_hit_q     <= s1_hit_d;
            s1_last_q    <= s1_last_d;
            s1_op_q      <= s1_op_d;
            s1_addr_q    <= s1_addr_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
            found_q      <= found_d;
            widx_q       <= widx_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            emit_q       <= emit_d;
            out_valid_q  <= out_valid_d;
            out_scalar_q <= out_scalar_d;
            out_addr_q   <= out_addr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_scalar = out_scalar_q;
    assign out_addr   = out_addr_q;

endmodule

// File: tb/tb_v_mask_reduce.sv
// Directed bench for v_mask_reduce: hand-computed cpop/first results, latency and framing.
module tb_v_mask_reduce;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_m0;
    logic [63:0] in_v0;
    logic        in_vm;
    logic [6:0]  in_lanes;
    logic        in_last;
    logic        in_opSel;
    logic [31:0] in_addr;
    logic        out_valid;
    logic [63:0] out_scalar;
    logic [31:0] out_addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    v_mask_reduce dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_m0      (in_m0),
        .in_v0      (in_v0),
        .in_vm      (in_vm),
        .in_lanes   (in_lanes),
        .in_last    (in_last),
        .in_opSel   (in_opSel),
        .in_addr    (in_addr),
        .out_valid  (out_valid),
        .out_scalar (out_scalar),
        .out_addr   (out_addr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word for one clock; returns 1 time unit after the capturing edge.
    task automatic send(input logic [63:0] m0, input logic [63:0] v0, input logic vm,
                        input logic [6:0] lanes, input logic last, input logic op,
                        input logic [31:0] addr);
        in_valid = 1'b1;
        in_m0    = m0;
        in_v0    = v0;
        in_vm    = vm;
        in_lanes = lanes;
        in_last  = last;
        in_opSel = op;
        in_addr  = addr;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_m0    = '0;
        in_last  = 1'b0;
    endtask

    // Called right after the last word's capturing edge (t+1); result due after edge t+4.
    task automatic expect_result(input string tag, input logic [63:0] scalar, input logic [31:0] addr);
        idle();
        tick();
        tick();
        chk({tag, "_early"}, 64'(out_valid), 64'd0);
        tick();
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_scalar"}, out_scalar, scalar);
        chk({tag, "_addr"}, 64'(out_addr), 64'(addr));
        tick();
        chk({tag, "_pulse"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic saw_valid;
        rst = 1'b1;
        idle();
        in_v0 = '0; in_vm = 1'b1; in_lanes = 7'd64; in_opSel = 1'b0; in_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_scalar", out_scalar, 64'd0);
        chk("rst_addr", 64'(out_addr), 64'd0);

        // cpop single word
        send(64'hF0F0_0000_0000_00FF, 64'd0, 1'b1, 7'd64, 1'b1, 1'b0, 32'd5);
        expect_result("cpop1", 64'd16, 32'd5);
        chk("hold_scalar", out_scalar, 64'd16);

        // first across two words
        send(64'd0, 64'd0, 1'b1, 7'd64, 1'b0, 1'b1, 32'd9);
        send(64'h100, 64'd0, 1'b1, 7'd64, 1'b1, 1'b1, 32'd9);
        expect_result("first2", 64'd72, 32'd9);

        // first with no bit set
        send(64'd0, 64'd0, 1'b1, 7'd64, 1'b0, 1'b1, 32'd11);
        send(64'd0, 64'd0, 1'b1, 7'd64, 1'b1, 1'b1, 32'd11);
        expect_result("first_none", 64'hFFFF_FFFF_FFFF_FFFF, 32'd11);

        // v0 masking
        send(64'hFF, 64'h0F, 1'b0, 7'd64, 1'b1, 1'b0, 32'd12);
        expect_result("cpop_v0", 64'd4, 32'd12);

        // lane clipping, zero lanes and clamp
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 7'd10, 1'b1, 1'b0, 32'd13);
        expect_result("lanes10", 64'd10, 32'd13);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 7'd0, 1'b1, 1'b0, 32'd14);
        expect_result("lanes0", 64'd0, 32'd14);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 7'd100, 1'b1, 1'b0, 32'd15);
        expect_result("lanes100", 64'd64, 32'd15);

        // back-to-back: A = cpop of two all-ones words, B = first of 0x2
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 7'd64, 1'b0, 1'b0, 32'd1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 7'd64, 1'b1, 1'b0, 32'd1);
        send(64'h2, 64'd0, 1'b1, 7'd64, 1'b1, 1'b1, 32'd2);
        idle();
        tick();
        chk("b2b_early", 64'(out_valid), 64'd0);
        tick();
        chk("b2b_a_valid", 64'(out_valid), 64'd1);
        chk("b2b_a_scalar", out_scalar, 64'd128);
        chk("b2b_a_addr", 64'(out_addr), 64'd1);
        tick();
        chk("b2b_b_valid", 64'(out_valid), 64'd1);
        chk("b2b_b_scalar", out_scalar, 64'd1);
        chk("b2b_b_addr", 64'(out_addr), 64'd2);
        tick();
        chk("b2b_end", 64'(out_valid), 64'd0);

        // 3-cycle gap inside a vector
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 7'd64, 1'b0, 1'b0, 32'd4);
        idle();
        tick();
        tick();
        tick();
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 7'd64, 1'b1, 1'b0, 32'd4);
        expect_result("gap", 64'd128, 32'd4);

        // reset mid-vector abandons it
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 7'd64, 1'b0, 1'b0, 32'd7);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
        end
        chk("midrst_novalid", 64'(saw_valid), 64'd0);
        chk("midrst_scalar", out_scalar, 64'd0);
        chk("midrst_addr", 64'(out_addr), 64'd0);
        send(64'h1, 64'd0, 1'b1, 7'd64, 1'b1, 1'b0, 32'd3);
        expect_result("post_rst", 64'd1, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/v_mask_reduce.md
Name: v_mask_reduce

Overview:
Mask-reduction stage that sits directly downstream of the mask logical unit (vMOP) in the vALU. It consumes a stream of mask words (one vector register's worth, one or more words) and produces a single scalar result for vcpop.m or vfirst.m. The result and its destination address go to the scalar writeback path. The pipeline is fire-and-forget with a valid strobe only and no backpressure, matching the other vALU units.

Parameters:
REQ_DATA_WIDTH, 64, mask word width W; must be a power of two.
RESP_DATA_WIDTH, 64, scalar result width.
REQ_ADDR_WIDTH, 32, destination address width.
LANE_WIDTH, 7, width of in_lanes; must satisfy 2^LANE_WIDTH > W.
IDX_WIDTH, 32, word-index counter width; saturates and does not wrap.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  mask word valid
in_m0  in  REQ_DATA_WIDTH  source mask word, bit i = element (word_idx*W + i)
in_v0  in  REQ_DATA_WIDTH  v0 enable word
in_vm  in  1  1 = unmasked (in_v0 ignored)
in_lanes  in  LANE_WIDTH  number of active low-order bits in this word; values > W are clamped to W
in_last  in  1  final word of the vector
in_opSel  in  1  0 = cpop, 1 = first; sampled on the first word only
in_addr  in  REQ_ADDR_WIDTH  destination; sampled on the first word only
out_valid  out  1  result strobe, one cycle
out_scalar  out  RESP_DATA_WIDTH  result
out_addr  out  REQ_ADDR_WIDTH  destination address

Behaviour:
- Reset: out_valid=0, out_scalar=0, out_addr=0. All pipeline registers, accumulators, word index and FSM are cleared, with the FSM returning to IDLE.
- Reset asserted mid-vector abandons the vector. No output is produced for it.
- S0 (register stage): captures w = in_m0 & (in_vm ? all-ones : in_v0) & lanemask(in_lanes), together with valid, last, opSel and addr.
  - lanemask(n) = low n bits set.
  - n = 0 gives a zero word that still counts as a word.
  - Invalid cycles load w = 0 and valid = 0.
- S1 (register stage): computes pop = popcount(w), ffs = index of the lowest set bit, and hit = |w.
- S2 (accumulate stage), FSM with two states, IDLE and ACCUM:
  - IDLE, valid word arrives:
    - latch opSel and addr;
    - cnt = pop, widx = 1;
    - found = hit, first = ffs;
    - if last, emit; otherwise go to ACCUM.
  - ACCUM, valid word arrives:
    - cnt += pop;
    - if !found && hit, then first = widx*W + ffs and found = 1;
    - widx += 1, saturating at all-ones;
    - if last, emit and return to IDLE.
  - Invalid cycles: state is held, so gaps mid-vector are legal.
  - Emit: on the next cycle, out_valid=1 and out_addr = latched addr. out_scalar is:
    - cpop: cnt, zero-extended;
    - first: first, zero-extended, if found; otherwise all-ones (-1).
- Latency: a word with in_last sampled at cycle t gives out_valid at t+4.
- Throughput: one word per cycle.
- Back-to-back vectors: the first word of vector B may arrive the cycle after vector A's last word. B's accumulation starts from B's word alone, with no bubble and no carry-over from A.
- Single-word vectors: in_last on the first word is legal, including every cycle in a row, giving one result per word.
- cnt width is RESP_DATA_WIDTH, so it cannot overflow for legal VLEN.
- out_valid is low on every cycle other than an emit. out_scalar and out_addr hold their last values when out_valid is low.

Decomposition:
- Shared package vmask_pkg holds:
  - constants VMR_CPOP = 1'b0 and VMR_FIRST = 1'b1;
  - state encodings VMR_IDLE and VMR_ACCUM;
  - a lanemask function.
- One natural sub-module, v_mask_word_scan: combinational popcount plus priority encoder over W bits, producing pop, ffs and hit. It is instantiated in front of the S1 register.

Test Plan:
- cpop, single word: in_m0=0xF0F0_0000_0000_00FF, vm=1, lanes=64, last=1, addr=5 -> one out_valid 4 cycles later with out_scalar=16, out_addr=5.
- first, multi-word: word0=0, word1=0x100, vm=1, lanes=64 each, last on word1 -> out_scalar = 64+8 = 72.
- first, none set: two zero words -> out_scalar=0xFFFF_FFFF_FFFF_FFFF. Also cpop with in_v0=0x0F, in_m0=0xFF, vm=0 -> 4.
- lanes: in_m0=all-ones, lanes=10, cpop -> 10. Repeat with lanes=0 -> 0. Repeat with lanes=100 -> 64 (clamped).
- back-to-back: vector A cpop (2 words of all-ones), then next cycle vector B first (single word 0x2) -> out_valid pulses 1 cycle apart with values 128 then 1. Also insert a 3-cycle in_valid gap inside A -> result unchanged.
- reset mid-op: send the first word of a 3-word vector, assert rst for 1 cycle -> no out_valid for that vector, all outputs 0. A fresh single-word cpop of 0x1 afterwards -> 1.
